// File: rtl/max7219_spi_serializer.sv
// Transmit side of the MAX7219 3-wire link: shifts 16-bit command words MSB-first and
// strobes LOAD after the word flagged as last so a daisy chain latches together.
module max7219_spi_serializer #(
  parameter int unsigned G_MAX_HALF_PERIOD = 4,
  parameter int unsigned G_LOAD_DURATION   = 4,
  parameter int unsigned G_DATA_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [G_DATA_WIDTH-1:0] i_data,
  input  logic                    i_last,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  output logic                    o_max7219_clk,
  output logic                    o_max7219_data,
  output logic                    o_max7219_load,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned MaxCnt = (G_MAX_HALF_PERIOD > G_LOAD_DURATION) ?
                                   G_MAX_HALF_PERIOD : G_LOAD_DURATION;
  localparam int unsigned CntW = $clog2(MaxCnt) + 1;
  localparam int unsigned BitW = $clog2(G_DATA_WIDTH);

  localparam logic [CntW-1:0] HalfLd = CntW'(G_MAX_HALF_PERIOD - 1);
  localparam logic [CntW-1:0] LoadLd = CntW'(G_LOAD_DURATION - 1);
  localparam logic [BitW-1:0] TopBit = BitW'(G_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLow,
    StShiftHigh,
    StLoad,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [G_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                    last_q, last_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
    end
  end

  // Phase counter counts down from its reload value; each phase lasts reload+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (i_data_valid) begin
          shift_d = i_data;
          last_d  = i_last;
          bit_d   = TopBit;
          cnt_d   = HalfLd;
          state_d = StShiftLow;
        end
      end
      StShiftLow: begin
        if (cnt_q == '0) begin
          cnt_d   = HalfLd;
          state_d = StShiftHigh;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StShiftHigh: begin
        if (cnt_q == '0) begin
          cnt_d = HalfLd;
          if (bit_q != '0) begin
            bit_d   = bit_q - BitW'(1);
            state_d = StShiftLow;
          end else if (last_q) begin
            cnt_d   = LoadLd;
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StLoad: begin
        if (cnt_q == '0) begin
          // Clearing the word drops DIN back to 0 once the latch strobe ends.
          shift_d = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_data_ready   = (state_q == StIdle);
  assign o_busy         = (state_q != StIdle);
  assign o_max7219_clk  = (state_q == StShiftHigh);
  assign o_max7219_load = (state_q == StLoad);
  assign o_done         = (state_q == StDone);
  // Between words bit_q rests at 0, so DIN keeps showing the last bit sent.
  assign o_max7219_data = shift_q[bit_q];

endmodule
